// File: rtl/jpeg_pkg.sv
// Shared constants, FIFO entry layout and sequencer states for the JPEG
// block fetch path between the frame SRAM and the 8x8 block pipeline.
package jpeg_pkg;

  localparam int PIXEL_W    = 8;
  localparam int BLK_DIM    = 8;
  localparam int WORD_W     = BLK_DIM * PIXEL_W;
  localparam int SRAM_AW    = 15;
  localparam int RA_W       = 11;
  localparam int CA_W       = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = 2;
  localparam int FIFO_CNT_W = 3;

  // Entry layout: {frameLast, blockLast, data}
  localparam int ENTRY_W    = WORD_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/jpeg_block_fetch_fifo.sv
// Four-entry output FIFO holding captured SRAM rows plus their block/frame
// end flags; reset flushes contents so a restarted frame never sees stale rows.
module jpeg_block_fetch_fifo
  import jpeg_pkg::*;
(
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iPush,
  input  logic [ENTRY_W-1:0]    iPushData,
  input  logic                  iPop,
  output logic [ENTRY_W-1:0]    oHead,
  output logic [FIFO_CNT_W-1:0] oCount
);

  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wrPtr_q;
  logic [FIFO_PTR_W-1:0] rdPtr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  pushEn;
  logic                  popEn;

  assign pushEn = iPush && (count_q != FIFO_CNT_W'(FIFO_DEPTH));
  assign popEn  = iPop && (count_q != '0);

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushEn) begin
        mem_q[wrPtr_q] <= iPushData;
        wrPtr_q        <= wrPtr_q + FIFO_PTR_W'(1);
      end
      if (popEn) begin
        rdPtr_q <= rdPtr_q + FIFO_PTR_W'(1);
      end
      case ({pushEn, popEn})
        2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
        2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign oHead  = mem_q[rdPtr_q];
  assign oCount = count_q;

endmodule

// File: rtl/jpeg_block_fetch.sv
// Walks a raster-stored frame in 8x8 block order, issuing one-cycle-latency
// SRAM reads under a credit limit and streaming rows out over valid/ready.
module jpeg_block_fetch
  import jpeg_pkg::*;
#(
  parameter int WPR_LOG2   = 6,
  parameter int BROWS_LOG2 = 6
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iStart,
  output logic              oNCE,
  output logic              oNWRT,
  output logic [RA_W-1:0]   oRA,
  output logic [CA_W-1:0]   oCA,
  input  logic [WORD_W-1:0] iDO,
  output logic [WORD_W-1:0] oData,
  output logic              oValid,
  input  logic              iReady,
  output logic              oBlockLast,
  output logic              oFrameLast,
  output logic              oBusy,
  output logic              oDone
);

  if (WPR_LOG2 + BROWS_LOG2 + 3 != SRAM_AW) begin : gBadGeometry
    $error("jpeg_block_fetch: WPR_LOG2 + BROWS_LOG2 + 3 must equal SRAM_AW");
  end

  state_e                  state_q, state_d;
  logic [2:0]              r_q, r_d;
  logic [WPR_LOG2-1:0]     bx_q, bx_d;
  logic [BROWS_LOG2-1:0]   by_q, by_d;
  logic                    nce_q, nce_d;
  logic [SRAM_AW-1:0]      addr_q, addr_d;
  logic                    reqBlk_q, reqBlk_d;
  logic                    reqFrm_q, reqFrm_d;
  logic                    capValid_q, capBlk_q, capFrm_q;
  logic                    done_q, done_d;

  logic [2:0]              curR;
  logic [WPR_LOG2-1:0]     curBx;
  logic [BROWS_LOG2-1:0]   curBy;
  logic                    issue;
  logic                    lastRead;
  logic                    hasCredit;
  logic [3:0]              outstanding;

  logic [ENTRY_W-1:0]      fifoHead;
  logic [FIFO_CNT_W-1:0]   fifoCount;
  logic                    pop;

  assign oValid = (fifoCount != '0);
  assign pop    = oValid && iReady;

  // Outstanding entries after this edge, assuming a read is issued now:
  // rows in the FIFO, the read on the bus, and the row on iDO, minus a pop.
  assign outstanding = {1'b0, fifoCount} + {3'b000, ~nce_q} + {3'b000, capValid_q}
                     - {3'b000, pop};
  assign hasCredit   = (outstanding < 4'(FIFO_DEPTH));

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    bx_d     = bx_q;
    by_d     = by_q;
    nce_d    = 1'b1;
    addr_d   = addr_q;
    reqBlk_d = 1'b0;
    reqFrm_d = 1'b0;
    done_d   = 1'b0;
    issue    = 1'b0;
    lastRead = 1'b0;
    curR     = r_q;
    curBx    = bx_q;
    curBy    = by_q;

    // The start cycle issues address 0 itself so the read lands one cycle later.
    case (state_q)
      IDLE: begin
        if (iStart) begin
          curR    = '0;
          curBx   = '0;
          curBy   = '0;
          issue   = 1'b1;
          state_d = RUN;
        end
      end
      RUN:   issue = hasCredit;
      DRAIN: begin
        if (pop && fifoHead[WORD_W+1]) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      lastRead = (curR == 3'(BLK_DIM - 1)) && (&curBx) && (&curBy);
      nce_d    = 1'b0;
      addr_d   = {curBy, curR, curBx};
      reqBlk_d = (curR == 3'(BLK_DIM - 1));
      reqFrm_d = lastRead;
      r_d      = curR + 3'd1;
      bx_d     = curBx;
      by_d     = curBy;
      if (curR == 3'(BLK_DIM - 1)) begin
        bx_d = curBx + WPR_LOG2'(1);
        if (&curBx) begin
          by_d = curBy + BROWS_LOG2'(1);
        end
      end
      if (lastRead) begin
        state_d = DRAIN;
      end
    end
  end

  // Read controls, the flag pipeline that follows each read, and sequencer state.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q    <= IDLE;
      r_q        <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      nce_q      <= 1'b1;
      addr_q     <= '0;
      reqBlk_q   <= 1'b0;
      reqFrm_q   <= 1'b0;
      capValid_q <= 1'b0;
      capBlk_q   <= 1'b0;
      capFrm_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      nce_q      <= nce_d;
      addr_q     <= addr_d;
      reqBlk_q   <= reqBlk_d;
      reqFrm_q   <= reqFrm_d;
      capValid_q <= ~nce_q;
      capBlk_q   <= reqBlk_q;
      capFrm_q   <= reqFrm_q;
      done_q     <= done_d;
    end
  end

  jpeg_block_fetch_fifo uFifo (
    .iClk      (iClk),
    .iReset    (iReset),
    .iPush     (capValid_q),
    .iPushData ({capFrm_q, capBlk_q, iDO}),
    .iPop      (pop),
    .oHead     (fifoHead),
    .oCount    (fifoCount)
  );

  assign oNCE       = nce_q;
  assign oNWRT      = 1'b1;
  assign oRA        = addr_q[SRAM_AW-1:CA_W];
  assign oCA        = addr_q[CA_W-1:0];
  assign oData      = fifoHead[WORD_W-1:0];
  assign oBlockLast = oValid && fifoHead[WORD_W];
  assign oFrameLast = oValid && fifoHead[WORD_W+1];
  assign oBusy      = (state_q != IDLE);
  assign oDone      = done_q;

endmodule

// File: tb/tb_jpeg_block_fetch.sv
// Directed bench for jpeg_block_fetch: SRAM model returns word[a]=a, and each
// transfer is compared against the block-order address it should carry.
module tb_jpeg_block_fetch;

  logic        iClk = 1'b0;
  logic        iReset;
  logic        iStart;
  logic        iReady;
  logic [63:0] iDO;
  logic        oNCE;
  logic        oNWRT;
  logic [10:0] oRA;
  logic [3:0]  oCA;
  logic [63:0] oData;
  logic        oValid;
  logic        oBlockLast;
  logic        oFrameLast;
  logic        oBusy;
  logic        oDone;

  int compared   = 0;
  int mismatched = 0;
  int k;
  int issued;
  int cyc;
  int budget;
  int doneSeen;
  int nceSeen;
  logic rdy;
  logic stb;

  always #5 iClk = ~iClk;

  // SRAM with one cycle of read latency; every word holds its own address.
  always @(posedge iClk) begin
    if (!oNCE) iDO <= {49'd0, oRA, oCA};
  end

  jpeg_block_fetch dut (
    .iClk       (iClk),
    .iReset     (iReset),
    .iStart     (iStart),
    .oNCE       (oNCE),
    .oNWRT      (oNWRT),
    .oRA        (oRA),
    .oCA        (oCA),
    .iDO        (iDO),
    .oData      (oData),
    .oValid     (oValid),
    .iReady     (iReady),
    .oBlockLast (oBlockLast),
    .oFrameLast (oFrameLast),
    .oBusy      (oBusy),
    .oDone      (oDone)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs for the current cycle, then step to 1ns after the next edge.
  task automatic applyStimulus(input logic start, input logic ready);
    iStart = start;
    iReady = ready;
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [14:0] scanAddr(input int n);
    logic [14:0] kk;
    kk = n[14:0];
    return {kk[14:9], kk[2:0], kk[8:3]};
  endfunction

  task automatic observeIssue(input string tag);
    if (!oNCE) begin
      checkOutput(tag, {49'd0, oRA, oCA}, {49'd0, scanAddr(issued)});
      issued++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".nce"},        oNCE,       1);
    checkOutput({tag, ".nwrt"},       oNWRT,      1);
    checkOutput({tag, ".ra"},         oRA,        0);
    checkOutput({tag, ".ca"},         oCA,        0);
    checkOutput({tag, ".valid"},      oValid,     0);
    checkOutput({tag, ".data"},       oData,      0);
    checkOutput({tag, ".blockLast"},  oBlockLast, 0);
    checkOutput({tag, ".frameLast"},  oFrameLast, 0);
    checkOutput({tag, ".busy"},       oBusy,      0);
    checkOutput({tag, ".done"},       oDone,      0);
  endtask

  initial begin
    iReset = 1'b1;
    iStart = 1'b0;
    iReady = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    checkResetValues("reset");
    iReset = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("idle.nce", oNCE, 1);

    // Frame A: full frame, consumer always ready, cycle 0 is the start cycle.
    $display("[TB] frame A: full frame with iReady=1");
    applyStimulus(1'b1, 1'b1);
    checkOutput("A.c1.nce",   oNCE,        0);
    checkOutput("A.c1.addr",  {oRA, oCA},  0);
    checkOutput("A.c1.valid", oValid,      0);
    checkOutput("A.c1.busy",  oBusy,       1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("A.c2.valid", oValid,      0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("A.c3.valid", oValid,      1);
    cyc = 3;
    k = 0;
    doneSeen = 0;
    while (k < 32768 && cyc < 33000) begin
      if (oValid) begin
        checkOutput("A.data",      oData,      {49'd0, scanAddr(k)});
        checkOutput("A.blockLast", oBlockLast, (k % 8) == 7);
        checkOutput("A.frameLast", oFrameLast, k == 32767);
        if (k == 32767) begin
          checkOutput("A.lastCycle", cyc,   32770);
          checkOutput("A.lastBusy",  oBusy, 1);
        end
        k++;
      end
      if (oDone) doneSeen++;
      applyStimulus(1'b0, 1'b1);
      cyc++;
    end
    checkOutput("A.transfers", k,        32768);
    checkOutput("A.earlyDone", doneSeen, 0);
    checkOutput("A.done",      oDone,    1);
    checkOutput("A.busyAfter", oBusy,    0);

    // Frame B: start right after oDone, stall 20 cycles, then random ready.
    $display("[TB] frame B: backpressure, random ready, reset at transfer 100");
    applyStimulus(1'b0, 1'b0);
    checkOutput("B.doneOneCycle", oDone, 0);
    applyStimulus(1'b1, 1'b0);
    issued = 0;
    k = 0;
    budget = 0;
    while (!oValid && budget < 10) begin
      observeIssue("B.addr");
      applyStimulus(1'b0, 1'b0);
      budget++;
    end
    checkOutput("B.firstValid", oValid, 1);
    for (int i = 0; i < 20; i++) begin
      observeIssue("B.addr");
      checkOutput("B.stallData", oData, 0);
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("B.stallReads", issued, 4);
    checkOutput("B.stallNce",   oNCE,   1);
    budget = 0;
    while (k < 100 && budget < 2000) begin
      rdy = (budget == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      stb = ((budget % 37) == 5);
      observeIssue("B.addr");
      checkOutput("B.outstanding", (issued - k) <= 4, 1);
      if (oValid && rdy) begin
        checkOutput("B.data",      oData,      {49'd0, scanAddr(k)});
        checkOutput("B.blockLast", oBlockLast, (k % 8) == 7);
        k++;
      end
      applyStimulus(stb, rdy);
      if (budget == 0) checkOutput("B.resume", oNCE, 0);
      budget++;
    end
    checkOutput("B.transfers", k, 100);
    iReset = 1'b1;
    #1;
    checkResetValues("midReset");
    doneSeen = 0;
    nceSeen = 0;
    repeat (3) begin
      applyStimulus(1'b0, 1'b1);
      if (oDone) doneSeen++;
    end
    iReset = 1'b0;
    repeat (10) begin
      applyStimulus(1'b0, 1'b1);
      if (oDone) doneSeen++;
      if (!oNCE) nceSeen++;
    end
    checkOutput("postReset.noDone",  doneSeen, 0);
    checkOutput("postReset.noReads", nceSeen,  0);

    // Frame C: restart after reset must begin again at address 0.
    $display("[TB] frame C: restart after reset with random ready");
    applyStimulus(1'b1, 1'b0);
    checkOutput("C.restartNce",  oNCE,       0);
    checkOutput("C.restartAddr", {oRA, oCA}, 0);
    issued = 0;
    k = 0;
    budget = 0;
    while (k < 2000 && budget < 8000) begin
      rdy = 1'($urandom_range(0, 1));
      observeIssue("C.addr");
      checkOutput("C.outstanding", (issued - k) <= 4, 1);
      if (oValid && rdy) begin
        checkOutput("C.data",      oData,      {49'd0, scanAddr(k)});
        checkOutput("C.blockLast", oBlockLast, (k % 8) == 7);
        checkOutput("C.frameLast", oFrameLast, 0);
        k++;
      end
      applyStimulus(1'b0, rdy);
      budget++;
    end
    checkOutput("C.transfers", k, 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
